avl_arbiter: RTL and testbench

AVL_ARBITER -- requirements
Module: avl_arbiter

---
 rtl/avl_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_avl_arbiter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/avl_arbiter.sv
// avl_arbiter: two-port (instruction/data) to single Avalon bridge arbiter.
// Each port has a one-entry pending buffer. At most one downstream
// transaction is outstanding. Requests issue combinationally from IDLE.
// Completions route back combinationally to the port recorded at grant.
//
// Ports:
//   clock, reset            - clock; synchronous active-high reset
//   i_imem_valid/addr       - instruction-port request pulse and address
//   o_imem_ready/rdata      - instruction-port completion pulse and data
//   i_dmem_valid/addr/wdata/wstrb - data-port request (wstrb 0 = load)
//   o_dmem_ready/rdata      - data-port completion pulse and data
//   o_avl_valid/instr/addr/wdata/wstrb - downstream request pulse and fields
//   i_avl_ready/rdata       - downstream completion pulse and data
// Parameter FAIR: 1 = round-robin on ties, 0 = data port always wins ties.
module avl_arbiter #(
   parameter bit FAIR = 1'b1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        i_imem_valid,
   input  logic [31:0] i_imem_addr,
   output logic [31:0] o_imem_rdata,
   output logic        o_imem_ready,
   input  logic        i_dmem_valid,
   input  logic [31:0] i_dmem_addr,
   input  logic [31:0] i_dmem_wdata,
   input  logic [3:0]  i_dmem_wstrb,
   output logic [31:0] o_dmem_rdata,
   output logic        o_dmem_ready,
   output logic        o_avl_valid,
   output logic        o_avl_instr,
   output logic [31:0] o_avl_addr,
   output logic [31:0] o_avl_wdata,
   output logic [3:0]  o_avl_wstrb,
   input  logic [31:0] i_avl_rdata,
   input  logic        i_avl_ready
);

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned SW = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_BUSY_I = 2'd1,
      ST_BUSY_D = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_next_state;

   logic          r_ip_valid;
   logic [AW-1:0] r_ip_addr;
   logic          r_dp_valid;
   logic [AW-1:0] r_dp_addr;
   logic [DW-1:0] r_dp_wdata;
   logic [SW-1:0] r_dp_wstrb;
   logic          r_last_d;    // 1 = last grant went to data port

   logic          w_i_acc;
   logic          w_d_acc;
   logic          w_i_cand;
   logic          w_d_cand;
   logic [AW-1:0] w_i_addr;
   logic [AW-1:0] w_d_addr;
   logic [DW-1:0] w_d_wdata;
   logic [SW-1:0] w_d_wstrb;
   logic          w_grant_i;
   logic          w_grant_d;

   // Candidate selection and grant. A pulse is accepted only when the port's
   // pending slot is empty and its own transaction is not outstanding; the
   // completion cycle no longer counts as outstanding, so a pulse there is kept.
   always_comb begin
      w_i_acc   = i_imem_valid & ~r_ip_valid &
                  ~((r_state == ST_BUSY_I) & ~i_avl_ready);
      w_d_acc   = i_dmem_valid & ~r_dp_valid &
                  ~((r_state == ST_BUSY_D) & ~i_avl_ready);
      w_i_cand  = (r_state == ST_IDLE) & (r_ip_valid | w_i_acc);
      w_d_cand  = (r_state == ST_IDLE) & (r_dp_valid | w_d_acc);
      w_i_addr  = r_ip_valid ? r_ip_addr  : i_imem_addr;
      w_d_addr  = r_dp_valid ? r_dp_addr  : i_dmem_addr;
      w_d_wdata = r_dp_valid ? r_dp_wdata : i_dmem_wdata;
      w_d_wstrb = r_dp_valid ? r_dp_wstrb : i_dmem_wstrb;
      w_grant_d = w_d_cand & (~w_i_cand | (FAIR == 1'b0) | ~r_last_d);
      w_grant_i = w_i_cand & ~w_grant_d;
   end

   // State register
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic; completion cycle always returns to IDLE (turnaround)
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_grant_d) begin
               w_next_state = ST_BUSY_D;
            end else if (w_grant_i) begin
               w_next_state = ST_BUSY_I;
            end
         end
         ST_BUSY_I, ST_BUSY_D: begin
            if (i_avl_ready) begin
               w_next_state = ST_IDLE;
            end
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   // Pending buffers and last-grant tracking
   always_ff @(posedge clock) begin
      if (reset) begin
         r_ip_valid <= 1'b0;
         r_ip_addr  <= '0;
         r_dp_valid <= 1'b0;
         r_dp_addr  <= '0;
         r_dp_wdata <= '0;
         r_dp_wstrb <= '0;
         r_last_d   <= 1'b0;
      end else begin
         if (w_grant_i) begin
            r_ip_valid <= 1'b0;
         end else if (w_i_acc) begin
            r_ip_valid <= 1'b1;
            r_ip_addr  <= i_imem_addr;
         end

         if (w_grant_d) begin
            r_dp_valid <= 1'b0;
         end else if (w_d_acc) begin
            r_dp_valid <= 1'b1;
            r_dp_addr  <= i_dmem_addr;
            r_dp_wdata <= i_dmem_wdata;
            r_dp_wstrb <= i_dmem_wstrb;
         end

         if (w_grant_d) begin
            r_last_d <= 1'b1;
         end else if (w_grant_i) begin
            r_last_d <= 1'b0;
         end
      end
   end

   // Output drive; everything held at zero while reset is asserted
   always_comb begin
      o_avl_valid  = 1'b0;
      o_avl_instr  = 1'b0;
      o_avl_addr   = '0;
      o_avl_wdata  = '0;
      o_avl_wstrb  = '0;
      o_imem_ready = 1'b0;
      o_imem_rdata = '0;
      o_dmem_ready = 1'b0;
      o_dmem_rdata = '0;
      if (!reset) begin
         if (w_grant_d) begin
            o_avl_valid = 1'b1;
            o_avl_addr  = w_d_addr;
            o_avl_wdata = w_d_wdata;
            o_avl_wstrb = w_d_wstrb;
         end else if (w_grant_i) begin
            o_avl_valid = 1'b1;
            o_avl_instr = 1'b1;
            o_avl_addr  = w_i_addr;
         end
         if ((r_state == ST_BUSY_I) && i_avl_ready) begin
            o_imem_ready = 1'b1;
            o_imem_rdata = i_avl_rdata;
         end
         if ((r_state == ST_BUSY_D) && i_avl_ready) begin
            o_dmem_ready = 1'b1;
            o_dmem_rdata = i_avl_rdata;
         end
      end
   end

endmodule

// File: tb/tb_avl_arbiter.sv
// tb_avl_arbiter: directed vector table on a FAIR=1 instance, plus a tie
// sequence comparing FAIR=1 (alternating) and FAIR=0 (data always) instances.
module tb_avl_arbiter;

   logic        clock;
   logic        reset;
   logic        iv;
   logic [31:0] ia;
   logic        dv;
   logic [31:0] da;
   logic [31:0] dwd;
   logic [3:0]  dws;
   logic        ardy;
   logic [31:0] ard;

   logic [31:0] f_irdata, f_drdata, f_aaddr, f_awdata;
   logic        f_irdy, f_drdy, f_avalid, f_ainstr;
   logic [3:0]  f_awstrb;
   logic [31:0] n_irdata, n_drdata, n_aaddr, n_awdata;
   logic        n_irdy, n_drdy, n_avalid, n_ainstr;
   logic [3:0]  n_awstrb;

   avl_arbiter #(.FAIR(1'b1)) u_fair (
      .clock(clock), .reset(reset),
      .i_imem_valid(iv), .i_imem_addr(ia),
      .o_imem_rdata(f_irdata), .o_imem_ready(f_irdy),
      .i_dmem_valid(dv), .i_dmem_addr(da), .i_dmem_wdata(dwd), .i_dmem_wstrb(dws),
      .o_dmem_rdata(f_drdata), .o_dmem_ready(f_drdy),
      .o_avl_valid(f_avalid), .o_avl_instr(f_ainstr), .o_avl_addr(f_aaddr),
      .o_avl_wdata(f_awdata), .o_avl_wstrb(f_awstrb),
      .i_avl_rdata(ard), .i_avl_ready(ardy)
   );

   avl_arbiter #(.FAIR(1'b0)) u_nofair (
      .clock(clock), .reset(reset),
      .i_imem_valid(iv), .i_imem_addr(ia),
      .o_imem_rdata(n_irdata), .o_imem_ready(n_irdy),
      .i_dmem_valid(dv), .i_dmem_addr(da), .i_dmem_wdata(dwd), .i_dmem_wstrb(dws),
      .o_dmem_rdata(n_drdata), .o_dmem_ready(n_drdy),
      .o_avl_valid(n_avalid), .o_avl_instr(n_ainstr), .o_avl_addr(n_aaddr),
      .o_avl_wdata(n_awdata), .o_avl_wstrb(n_awstrb),
      .i_avl_rdata(ard), .i_avl_ready(ardy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic         rst;
      logic         iv;
      logic [31:0]  ia;
      logic         dv;
      logic [31:0]  da;
      logic [31:0]  dwd;
      logic [3:0]   dws;
      logic         ardy;
      logic [31:0]  ard;
      logic [135:0] exp;
   } vec_t;

   int passed = 0;
   int total  = 0;

   // Expected bundle: {avl_valid, avl_instr, addr, wdata, wstrb, i_rdy, i_rdata, d_rdy, d_rdata}
   function automatic logic [135:0] ex(input logic av, input logic ai, input logic [31:0] aa,
                                       input logic [31:0] aw, input logic [3:0] as,
                                       input logic ir, input logic [31:0] ird,
                                       input logic dr, input logic [31:0] drd);
      return {av, ai, aa, aw, as, ir, ird, dr, drd};
   endfunction

   function automatic vec_t mv(input logic r, input logic i_v, input logic [31:0] i_a,
                               input logic d_v, input logic [31:0] d_a, input logic [31:0] d_w,
                               input logic [3:0] d_s, input logic a_r, input logic [31:0] a_d,
                               input logic [135:0] e);
      vec_t v;
      v.rst = r; v.iv = i_v; v.ia = i_a; v.dv = d_v; v.da = d_a; v.dwd = d_w;
      v.dws = d_s; v.ardy = a_r; v.ard = a_d; v.exp = e;
      return v;
   endfunction

   function automatic logic [135:0] fair_out();
      return {f_avalid, f_ainstr, f_aaddr, f_awdata, f_awstrb, f_irdy, f_irdata, f_drdy, f_drdata};
   endfunction

   vec_t vecs[28];
   logic [135:0] z;
   logic [1:0] got_f, got_n, exp_f;

   initial begin
      z = '0;
      reset = 1'b1; iv = 0; ia = 0; dv = 0; da = 0; dwd = 0; dws = 0; ardy = 0; ard = 0;

      vecs[0]  = mv(1, 0, 0,      0, 0, 0, 0, 0, 0, z);
      vecs[1]  = mv(1, 1, 32'h100, 0, 0, 0, 0, 0, 0, z);
      vecs[2]  = mv(0, 1, 32'h100, 0, 0, 0, 0, 0, 0, ex(1, 1, 32'h100, 0, 0, 0, 0, 0, 0));
      vecs[3]  = mv(0, 0, 0,      0, 0, 0, 0, 0, 0, z);
      vecs[4]  = mv(0, 0, 0,      0, 0, 0, 0, 1, 32'h13, ex(0, 0, 0, 0, 0, 1, 32'h13, 0, 0));
      vecs[5]  = mv(1, 0, 0,      0, 0, 0, 0, 0, 0, z);
      vecs[6]  = mv(0, 1, 32'h200, 1, 32'h8000, 32'hDEADBEEF, 4'hF, 0, 0,
                    ex(1, 0, 32'h8000, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0));
      vecs[7]  = mv(0, 0, 0,      0, 0, 0, 0, 0, 0, z);
      vecs[8]  = mv(0, 0, 0,      0, 0, 0, 0, 1, 32'h0BAD0001, ex(0, 0, 0, 0, 0, 0, 0, 1, 32'h0BAD0001));
      vecs[9]  = mv(0, 0, 0,      0, 0, 0, 0, 0, 0, ex(1, 1, 32'h200, 0, 0, 0, 0, 0, 0));
      vecs[10] = mv(0, 0, 0,      1, 32'h40, 0, 0, 0, 0, z);
      vecs[11] = mv(0, 0, 0,      0, 0, 0, 0, 1, 32'hCAFE0001, ex(0, 0, 0, 0, 0, 1, 32'hCAFE0001, 0, 0));
      vecs[12] = mv(0, 0, 0,      0, 0, 0, 0, 0, 0, ex(1, 0, 32'h40, 0, 0, 0, 0, 0, 0));
      vecs[13] = mv(0, 0, 0,      0, 0, 0, 0, 1, 32'h55AA, ex(0, 0, 0, 0, 0, 0, 0, 1, 32'h55AA));
      vecs[14] = mv(0, 0, 0,      1, 32'h80, 32'h1234, 4'h3, 0, 0, ex(1, 0, 32'h80, 32'h1234, 4'h3, 0, 0, 0, 0));
      vecs[15] = mv(0, 0, 0,      1, 32'h84, 32'h9999, 4'hF, 0, 0, z);
      vecs[16] = mv(0, 0, 0,      0, 0, 0, 0, 1, 32'h77, ex(0, 0, 0, 0, 0, 0, 0, 1, 32'h77));
      vecs[17] = mv(0, 0, 0,      0, 0, 0, 0, 0, 0, z);
      vecs[18] = mv(0, 0, 0,      0, 0, 0, 0, 0, 0, z);
      vecs[19] = mv(0, 0, 0,      0, 0, 0, 0, 1, 32'h99, z);
      vecs[20] = mv(0, 0, 0,      1, 32'h90, 0, 0, 0, 0, ex(1, 0, 32'h90, 0, 0, 0, 0, 0, 0));
      vecs[21] = mv(1, 0, 0,      0, 0, 0, 0, 0, 0, z);
      vecs[22] = mv(0, 0, 0,      0, 0, 0, 0, 1, 32'h5, z);
      vecs[23] = mv(0, 0, 0,      0, 0, 0, 0, 0, 0, z);
      vecs[24] = mv(0, 1, 32'h300, 0, 0, 0, 0, 0, 0, ex(1, 1, 32'h300, 0, 0, 0, 0, 0, 0));
      vecs[25] = mv(0, 0, 0,      1, 32'h44, 0, 0, 1, 32'h1, ex(0, 0, 0, 0, 0, 1, 32'h1, 0, 0));
      vecs[26] = mv(0, 0, 0,      0, 0, 0, 0, 0, 0, ex(1, 0, 32'h44, 0, 0, 0, 0, 0, 0));
      vecs[27] = mv(0, 0, 0,      0, 0, 0, 0, 1, 32'h2, ex(0, 0, 0, 0, 0, 0, 0, 1, 32'h2));

      for (int i = 0; i < 28; i++) begin
         @(negedge clock);
         reset = vecs[i].rst; iv = vecs[i].iv; ia = vecs[i].ia;
         dv = vecs[i].dv; da = vecs[i].da; dwd = vecs[i].dwd; dws = vecs[i].dws;
         ardy = vecs[i].ardy; ard = vecs[i].ard;
         #1;
         total++;
         if (fair_out() === vecs[i].exp) passed++;
         else $display("FAIL vec%0d: got %h want %h", i, fair_out(), vecs[i].exp);
      end

      // Tie sequence: both ports pulse every cycle, ready answers the cycle after each issue
      @(negedge clock);
      reset = 1; iv = 0; dv = 0; ardy = 0; ard = 0; dwd = 0; dws = 0;
      @(negedge clock);
      reset = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clock);
         iv = 1; ia = 32'h1000; dv = 1; da = 32'h2000; ardy = k[0]; ard = 32'(k);
         #1;
         if (k % 2 == 0) begin
            got_f = {f_avalid, f_ainstr};
            exp_f = {1'b1, (k % 4 == 2)};
            total++;
            if (got_f === exp_f) passed++;
            else $display("FAIL tie_fair%0d: got %b want %b", k, got_f, exp_f);
            got_n = {n_avalid, n_ainstr};
            total++;
            if (got_n === 2'b10) passed++;
            else $display("FAIL tie_fixed%0d: got %b want 10", k, got_n);
         end
      end
      @(negedge clock);
      iv = 0; dv = 0; ardy = 0;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
